parking_lot_sensor: RTL and testbench

//  Upstream stage of the parking-lot occupancy counter. Takes the two optical

---
 rtl/parking_lot_sensor.sv | 174 +++++++++++++++++
 tb/tb_parking_lot_sensor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_lot_sensor.sv
`default_nettype none
// ============================================================================
// parking_lot_sensor : gate sensor debounce + entry/exit sequence tracker
// Revision 1.0
// ============================================================================
module parking_lot_sensor #(
    parameter int DB_CYCLES = 1000,
    parameter int DB_W      = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic inc,
    output logic dec,
    output logic fault,
    output logic busy
);

    localparam logic [DB_W-1:0] C_DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EN1   = 3'd1,
        S_EN2   = 3'd2,
        S_EN3   = 3'd3,
        S_EX1   = 3'd4,
        S_EX2   = 3'd5,
        S_EX3   = 3'd6,
        S_ABORT = 3'd7
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_p;
    state_t     r_state;
    state_t     w_next;
    logic       w_inc;
    logic       w_dec;
    logic       w_fault;
    logic       r_inc;
    logic       r_dec;
    logic       r_fault;

    // Bit 1 is the outer sensor (A), bit 0 the inner sensor (B).
    assign w_raw = {sensor_a, sensor_b};

    for (genvar i = 0; i < 2; i++) begin : g_db
        logic            r_meta;
        logic            r_sync;
        logic            r_filt;
        logic [DB_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
                r_filt <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_meta <= w_raw[i];
                r_sync <= r_meta;
                if (r_sync == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_DB_LAST) begin
                    r_filt <= r_sync;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_p[i] = r_filt;
    end

    always_comb begin
        w_next = r_state;
        w_inc  = 1'b0;
        w_dec  = 1'b0;
        case (r_state)
            S_IDLE: begin
                case (w_p)
                    2'b10:   w_next = S_EN1;
                    2'b01:   w_next = S_EX1;
                    2'b11:   w_next = S_ABORT;
                    default: ;
                endcase
            end
            S_EN1: begin
                case (w_p)
                    2'b00:   w_next = S_IDLE;
                    2'b11:   w_next = S_EN2;
                    2'b01:   w_next = S_ABORT;
                    default: ;
                endcase
            end
            S_EN2: begin
                case (w_p)
                    2'b10:   w_next = S_EN1;
                    2'b01:   w_next = S_EN3;
                    2'b00:   w_next = S_ABORT;
                    default: ;
                endcase
            end
            S_EN3: begin
                case (w_p)
                    2'b11:   w_next = S_EN2;
                    2'b10:   w_next = S_ABORT;
                    2'b00: begin
                        w_next = S_IDLE;
                        w_inc  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EX1: begin
                case (w_p)
                    2'b00:   w_next = S_IDLE;
                    2'b11:   w_next = S_EX2;
                    2'b10:   w_next = S_ABORT;
                    default: ;
                endcase
            end
            S_EX2: begin
                case (w_p)
                    2'b01:   w_next = S_EX1;
                    2'b10:   w_next = S_EX3;
                    2'b00:   w_next = S_ABORT;
                    default: ;
                endcase
            end
            S_EX3: begin
                case (w_p)
                    2'b11:   w_next = S_EX2;
                    2'b01:   w_next = S_ABORT;
                    2'b00: begin
                        w_next = S_IDLE;
                        w_dec  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_ABORT: begin
                if (w_p == 2'b00) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Staying in ABORT is not a new fault; only the entry edge pulses.
        w_fault = (w_next == S_ABORT) && (r_state != S_ABORT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_inc   <= w_inc;
            r_dec   <= w_dec;
            r_fault <= w_fault;
        end
    end

    assign inc   = r_inc;
    assign dec   = r_dec;
    assign fault = r_fault;
    assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_parking_lot_sensor.sv
`default_nettype none
// ============================================================================
// tb_parking_lot_sensor : scoreboard bench for the gate sensor sequencer
// Revision 1.0
// ============================================================================
module tb_parking_lot_sensor;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;
    localparam logic [2:0] K_INC   = 3'b100;
    localparam logic [2:0] K_DEC   = 3'b010;
    localparam logic [2:0] K_FAULT = 3'b001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sensor_a = 1'b0;
    logic sensor_b = 1'b0;
    logic inc;
    logic dec;
    logic fault;
    logic busy;

    parking_lot_sensor #(
        .DB_CYCLES(DB),
        .DB_W     (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sensor_a(sensor_a),
        .sensor_b(sensor_b),
        .inc     (inc),
        .dec     (dec),
        .fault   (fault),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] kind;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pulses = 0;
    int   drv_cyc  = 0;

    // Output side of the scoreboard: every pulse must match the queue head.
    always @(negedge clk) begin
        if ({inc, dec, fault} !== 3'b000) begin
            exp_t e;
            n_pulses = n_pulses + 1;
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: got {inc,dec,fault}=%b at cycle %0d, required none", {inc, dec, fault}, cyc);
            end else begin
                e = exp_q.pop_front();
                if ({inc, dec, fault} !== e.kind || cyc != e.at)
                    $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d", {inc, dec, fault}, cyc, e.kind, e.at);
                else
                    n_pass = n_pass + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic b);
        sensor_a = a;
        sensor_b = b;
        drv_cyc  = cyc;
    endtask

    task automatic expect_pulse(input logic [2:0] kind);
        exp_t e;
        e.kind = kind;
        e.at   = drv_cyc + LAT;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        int p0;
        p0 = n_pulses;
        reset = 1'b1;
        drive(1'b1, 1'b1);
        tick(3);
        n_checks++;
        if ({inc, dec, fault, busy} !== 4'b0000)
            $display("FAIL reset_outputs: got %b, required 0000", {inc, dec, fault, busy});
        else n_pass++;
        n_checks++;
        if (dut.w_p !== 2'b00)
            $display("FAIL reset_filtered: got %b, required 00", dut.w_p);
        else n_pass++;
        reset = 1'b0;
        drv_cyc = cyc;
        expect_pulse(K_FAULT);
        tick(LAT + 3);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL reset_11_abort_busy: got %b, required 1", busy);
        else n_pass++;
        drive(1'b0, 1'b0);
        tick(LAT + 3);
        n_checks++;
        if (busy !== 1'b0 || n_pulses - p0 != 1 || exp_q.size() != 0)
            $display("FAIL reset_11_release: busy=%b pulses=%0d pending=%0d, required busy=0 pulses=1 pending=0", busy, n_pulses - p0, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_entry;
        int p0;
        p0 = n_pulses;
        drive(1'b1, 1'b0); tick(20);
        drive(1'b1, 1'b1); tick(20);
        drive(1'b0, 1'b1); tick(20);
        drive(1'b0, 1'b0);
        expect_pulse(K_INC);
        tick(LAT - 1);
        n_checks++;
        if (inc !== 1'b0) $display("FAIL entry_early: inc=%b one cycle before, required 0", inc);
        else n_pass++;
        tick(1);
        n_checks++;
        if (inc !== 1'b1 || dec !== 1'b0 || fault !== 1'b0)
            $display("FAIL entry_latency: got {inc,dec,fault}=%b, required 100", {inc, dec, fault});
        else n_pass++;
        tick(20);
        n_checks++;
        if (n_pulses - p0 != 1 || exp_q.size() != 0 || busy !== 1'b0)
            $display("FAIL entry_count: pulses=%0d pending=%0d busy=%b, required 1 0 0", n_pulses - p0, exp_q.size(), busy);
        else n_pass++;
    endtask

    task automatic test_exit;
        int p0;
        p0 = n_pulses;
        drive(1'b0, 1'b1);
        tick(LAT + 1);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL exit_busy_start: got %b, required 1", busy);
        else n_pass++;
        tick(11);
        drive(1'b1, 1'b1); tick(20);
        drive(1'b1, 1'b0); tick(20);
        drive(1'b0, 1'b0);
        expect_pulse(K_DEC);
        tick(LAT - 1);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL exit_busy_hold: got %b, required 1", busy);
        else n_pass++;
        tick(1);
        n_checks++;
        if (busy !== 1'b0 || dec !== 1'b1)
            $display("FAIL exit_end: busy=%b dec=%b, required busy=0 dec=1", busy, dec);
        else n_pass++;
        tick(20);
        n_checks++;
        if (n_pulses - p0 != 1 || exp_q.size() != 0)
            $display("FAIL exit_count: pulses=%0d pending=%0d, required 1 0", n_pulses - p0, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reverse;
        int p0;
        p0 = n_pulses;
        drive(1'b1, 1'b0); tick(20);
        drive(1'b1, 1'b1); tick(20);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL reverse_busy: got %b, required 1", busy);
        else n_pass++;
        drive(1'b1, 1'b0); tick(20);
        drive(1'b0, 1'b0); tick(20);
        n_checks++;
        if (busy !== 1'b0 || n_pulses - p0 != 0)
            $display("FAIL reverse_end: busy=%b pulses=%0d, required 0 0", busy, n_pulses - p0);
        else n_pass++;
    endtask

    task automatic test_glitch;
        int p0;
        int d0;
        p0 = n_pulses;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0); tick(3);
            drive(1'b0, 1'b0); tick(3);
            n_checks++;
            if (dut.w_p !== 2'b00 || busy !== 1'b0)
                $display("FAIL glitch_%0d: f=%b busy=%b, required f=00 busy=0", i, dut.w_p, busy);
            else n_pass++;
        end
        tick(10);
        drive(1'b1, 1'b0);
        d0 = drv_cyc;
        tick(DB);
        drive(1'b0, 1'b0);
        tick(d0 + LAT - cyc);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL glitch_boundary_pass: busy=%b, required 1", busy);
        else n_pass++;
        tick(10);
        n_checks++;
        if (busy !== 1'b0 || n_pulses - p0 != 0)
            $display("FAIL glitch_end: busy=%b pulses=%0d, required 0 0", busy, n_pulses - p0);
        else n_pass++;
    endtask

    task automatic test_both;
        int p0;
        p0 = n_pulses;
        drive(1'b1, 1'b1);
        expect_pulse(K_FAULT);
        tick(LAT + 1);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL both_abort: busy=%b, required 1", busy);
        else n_pass++;
        tick(30);
        n_checks++;
        if (busy !== 1'b1 || n_pulses - p0 != 1)
            $display("FAIL both_hold: busy=%b pulses=%0d, required 1 1", busy, n_pulses - p0);
        else n_pass++;
        drive(1'b0, 1'b0);
        tick(LAT + 3);
        n_checks++;
        if (busy !== 1'b0 || n_pulses - p0 != 1 || exp_q.size() != 0)
            $display("FAIL both_release: busy=%b pulses=%0d pending=%0d, required 0 1 0", busy, n_pulses - p0, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int p0;
        p0 = n_pulses;
        drive(1'b1, 1'b0); tick(20);
        drive(1'b1, 1'b1); tick(20);
        drive(1'b0, 1'b1); tick(20);
        reset = 1'b1;
        drive(1'b0, 1'b0);
        tick(1);
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || dut.w_p !== 2'b00)
            $display("FAIL reset_mid: busy=%b f=%b, required busy=0 f=00", busy, dut.w_p);
        else n_pass++;
        tick(20);
        n_checks++;
        if (n_pulses - p0 != 0) $display("FAIL reset_mid_no_inc: pulses=%0d, required 0", n_pulses - p0);
        else n_pass++;
        drive(1'b1, 1'b0); tick(20);
        drive(1'b1, 1'b1); tick(20);
        drive(1'b0, 1'b1); tick(20);
        drive(1'b0, 1'b0);
        expect_pulse(K_INC);
        tick(20);
        n_checks++;
        if (n_pulses - p0 != 1 || exp_q.size() != 0)
            $display("FAIL reset_mid_entry: pulses=%0d pending=%0d, required 1 0", n_pulses - p0, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_entry();
        test_exit();
        test_reverse();
        test_glitch();
        test_both();
        test_reset_mid();
        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
